// File: rtl/register_file_mp_if.sv
// Bus bundle for the multi-port register file: read ports, writeback ports,
// the issue-stage reservation handshake and the live pending count.
interface register_file_mp_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1
);
    localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W  = $clog2(NUM_REGS + 1);

    logic [NUM_RD*ADDR_W-1:0] rsel;
    logic [NUM_RD*DATA_W-1:0] rdat;
    logic [NUM_RD-1:0]        rbusy;
    logic [NUM_WR-1:0]        wen;
    logic [NUM_WR*ADDR_W-1:0] wsel;
    logic [NUM_WR*DATA_W-1:0] wdat;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_sel;
    logic                     rsv_ok;
    logic [CNT_W-1:0]         busy_cnt;

    modport master (
        output rsel, wen, wsel, wdat, rsv_en, rsv_sel,
        input  rdat, rbusy, rsv_ok, busy_cnt
    );

    modport slave (
        input  rsel, wen, wsel, wdat, rsv_en, rsv_sel,
        output rdat, rbusy, rsv_ok, busy_cnt
    );
endinterface

// File: rtl/register_file_mp.sv
// Parametrised decode-stage register file with optional write-to-read bypass
// and a per-register pending scoreboard driven by the issue stage.
module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input logic               CLK,
    input logic               RST,
    register_file_mp_if.slave bus
);
    localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W  = $clog2(NUM_REGS + 1);

    logic [DATA_W-1:0]   regs     [NUM_REGS];
    logic [DATA_W-1:0]   regs_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_nxt;

    logic [ADDR_W-1:0]   wa     [NUM_WR];
    logic [DATA_W-1:0]   wd     [NUM_WR];
    logic [NUM_WR-1:0]   wr_ok;
    logic [ADDR_W-1:0]   ra     [NUM_RD];
    logic [DATA_W-1:0]   rd_val [NUM_RD];
    logic [NUM_RD-1:0]   rb_val;

    logic                sel_busy;
    logic                rsv_ok_c;
    logic                rsv_take;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    // Address 0 is hardwired when ZERO_REG is set, so it never takes writes or reservations.
    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return in_range(a) && !(ZERO_REG != 0 && a == '0);
    endfunction

    for (genvar i = 0; i < NUM_WR; i++) begin : g_wr
        assign wa[i]    = bus.wsel[i*ADDR_W +: ADDR_W];
        assign wd[i]    = bus.wdat[i*DATA_W +: DATA_W];
        assign wr_ok[i] = bus.wen[i] && writable(wa[i]);
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign ra[k]                         = bus.rsel[k*ADDR_W +: ADDR_W];
        assign bus.rdat[k*DATA_W +: DATA_W] = rd_val[k];
        assign bus.rbusy[k]                  = rb_val[k];
    end

    // The handshake only looks at the stored pending bit, never at same-cycle writes.
    always_comb begin
        sel_busy = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (bus.rsv_sel == ADDR_W'(r)) begin
                sel_busy = busy[r];
            end
        end
        rsv_ok_c = bus.rsv_en && in_range(bus.rsv_sel) && !sel_busy;
        rsv_take = rsv_ok_c && writable(bus.rsv_sel);
    end

    // Ports are scanned upward so the highest index wins; an accepted reservation is applied last.
    always_comb begin
        busy_nxt = busy;
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_nxt[r] = regs[r];
        end
        for (int i = 0; i < NUM_WR; i++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wr_ok[i] && wa[i] == ADDR_W'(r)) begin
                    regs_nxt[r] = wd[i];
                    busy_nxt[r] = 1'b0;
                end
            end
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rsv_take && bus.rsv_sel == ADDR_W'(r)) begin
                busy_nxt[r] = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[r]);
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_val[k] = '0;
            rb_val[k] = 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (ra[k] == ADDR_W'(r) && !(ZERO_REG != 0 && r == 0)) begin
                    rd_val[k] = regs[r];
                    rb_val[k] = busy[r];
                end
            end
            if (BYPASS != 0) begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (wr_ok[i] && wa[i] == ra[k]) begin
                        rd_val[k] = wd[i];
                        rb_val[k] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            busy  <= '0;
            cnt_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= regs_nxt[r];
            end
            busy  <= busy_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    assign bus.rsv_ok   = rsv_ok_c;
    assign bus.busy_cnt = cnt_q;
endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: default config (bypass), a no-bypass copy and a
// 24-register / 3-read / 2-write config checked against a behavioural model.
module tb_register_file_mp;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    register_file_mp_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(1)) if_a ();
    register_file_mp_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(1)) if_b ();
    register_file_mp_if #(.DATA_W(16), .NUM_REGS(24), .NUM_RD(3), .NUM_WR(2)) if_c ();

    register_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(1), .BYPASS(1), .ZERO_REG(1))
        u_a (.CLK(CLK), .RST(RST), .bus(if_a));
    register_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(1), .BYPASS(0), .ZERO_REG(1))
        u_b (.CLK(CLK), .RST(RST), .bus(if_b));
    register_file_mp #(.DATA_W(16), .NUM_REGS(24), .NUM_RD(3), .NUM_WR(2), .BYPASS(1), .ZERO_REG(1))
        u_c (.CLK(CLK), .RST(RST), .bus(if_c));

    typedef struct {
        logic        wen;
        logic [4:0]  wsel;
        logic [31:0] wdat;
        logic        rsv_en;
        logic [4:0]  rsv_sel;
        logic [4:0]  rsel0;
        logic [4:0]  rsel1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic        e_rb0;
        logic        e_ok;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs [12];

    logic [15:0] m_mem  [24];
    logic        m_busy [24];
    logic [1:0]  r_wen;
    int          r_ws   [2];
    logic [15:0] r_wd   [2];
    logic        r_en;
    int          r_rs;
    int          r_rd   [3];
    logic [15:0] e_d;
    logic        e_b;
    logic        e_ok;
    int          e_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 6'd0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd5, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1, 6'd1};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd3, 32'h0,        32'h0,        1'b1, 1'b0, 6'd1};
        vecs[4]  = '{1'b1, 5'd3, 32'hA5,       1'b0, 5'd0, 5'd3, 5'd5, 32'hA5,       32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'hA5,       32'hA5,       1'b0, 1'b0, 6'd0};
        vecs[6]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd3, 32'h0,        32'hA5,       1'b0, 1'b1, 6'd0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
        vecs[8]  = '{1'b1, 5'd9, 32'h12345678, 1'b1, 5'd9, 5'd9, 5'd9, 32'h12345678, 32'h12345678, 1'b0, 1'b1, 6'd1};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd5, 32'h12345678, 32'hDEADBEEF, 1'b1, 1'b0, 6'd1};
        vecs[10] = '{1'b1, 5'd7, 32'h1234,     1'b1, 5'd9, 5'd7, 5'd9, 32'h1234,     32'h12345678, 1'b0, 1'b0, 6'd1};
        vecs[11] = '{1'b1, 5'd9, 32'h55,       1'b0, 5'd0, 5'd9, 5'd7, 32'h55,       32'h1234,     1'b0, 1'b0, 6'd0};

        if_a.rsel = '0; if_a.wen = '0; if_a.wsel = '0; if_a.wdat = '0; if_a.rsv_en = 1'b0; if_a.rsv_sel = '0;
        if_b.rsel = '0; if_b.wen = '0; if_b.wsel = '0; if_b.wdat = '0; if_b.rsv_en = 1'b0; if_b.rsv_sel = '0;
        if_c.rsel = '0; if_c.wen = '0; if_c.wsel = '0; if_c.wdat = '0; if_c.rsv_en = 1'b0; if_c.rsv_sel = '0;

        RST = 1'b1;
        repeat (2) tick();
        RST = 1'b0;

        check("a_reset_cnt", if_a.busy_cnt, 6'd0);
        for (int r = 0; r < 32; r++) begin
            if_a.rsel = {5'(31 - r), 5'(r)};
            #1;
            check($sformatf("a_reset_rd0_r%0d", r), if_a.rdat[31:0], 32'h0);
            check($sformatf("a_reset_rb0_r%0d", r), if_a.rbusy[0], 1'b0);
            tick();
        end

        for (int v = 0; v < 12; v++) begin
            if_a.wen     = vecs[v].wen;
            if_a.wsel    = vecs[v].wsel;
            if_a.wdat    = vecs[v].wdat;
            if_a.rsv_en  = vecs[v].rsv_en;
            if_a.rsv_sel = vecs[v].rsv_sel;
            if_a.rsel    = {vecs[v].rsel1, vecs[v].rsel0};
            #1;
            check($sformatf("a_vec%0d_rd0", v), if_a.rdat[31:0], vecs[v].e_rd0);
            check($sformatf("a_vec%0d_rd1", v), if_a.rdat[63:32], vecs[v].e_rd1);
            check($sformatf("a_vec%0d_rb0", v), if_a.rbusy[0], vecs[v].e_rb0);
            check($sformatf("a_vec%0d_ok", v), if_a.rsv_ok, vecs[v].e_ok);
            tick();
            check($sformatf("a_vec%0d_cnt", v), if_a.busy_cnt, vecs[v].e_cnt);
        end

        // reset wins over a same-cycle write and reservation
        if_a.wen = 1'b1; if_a.wsel = 5'd5; if_a.wdat = 32'hAAAA;
        if_a.rsv_en = 1'b1; if_a.rsv_sel = 5'd11;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        if_a.wen = 1'b0; if_a.rsv_en = 1'b0;
        if_a.rsel = {5'd11, 5'd5};
        #1;
        check("a_rst_r5", if_a.rdat[31:0], 32'h0);
        check("a_rst_rb11", if_a.rbusy[1], 1'b0);
        check("a_rst_cnt", if_a.busy_cnt, 6'd0);
        tick();

        // no-bypass instance: write visible one cycle later, pending seen during write
        if_b.rsel = {5'd0, 5'd7};
        if_b.wen = 1'b1; if_b.wsel = 5'd7; if_b.wdat = 32'h1234;
        #1;
        check("b_wr_same_cycle", if_b.rdat[31:0], 32'h0);
        tick();
        if_b.wen = 1'b0;
        #1;
        check("b_wr_next_cycle", if_b.rdat[31:0], 32'h1234);
        tick();
        if_b.rsv_en = 1'b1; if_b.rsv_sel = 5'd3;
        #1;
        check("b_rsv_ok", if_b.rsv_ok, 1'b1);
        tick();
        if_b.rsv_en = 1'b0;
        check("b_rsv_cnt", if_b.busy_cnt, 6'd1);
        if_b.rsel = {5'd0, 5'd3};
        if_b.wen = 1'b1; if_b.wsel = 5'd3; if_b.wdat = 32'hA5;
        #1;
        check("b_wr_rb_during", if_b.rbusy[0], 1'b1);
        check("b_wr_rd_during", if_b.rdat[31:0], 32'h0);
        tick();
        if_b.wen = 1'b0;
        #1;
        check("b_wr_rb_after", if_b.rbusy[0], 1'b0);
        check("b_wr_rd_after", if_b.rdat[31:0], 32'hA5);
        check("b_wr_cnt_after", if_b.busy_cnt, 6'd0);
        tick();

        // 24-register config: port collision, out-of-range, fill the scoreboard
        if_c.wen = 2'b11; if_c.wsel = {5'd4, 5'd4}; if_c.wdat = {16'h2222, 16'h1111};
        if_c.rsel = {5'd0, 5'd30, 5'd4};
        if_c.rsv_en = 1'b1; if_c.rsv_sel = 5'd30;
        #1;
        check("c_collide_bypass", if_c.rdat[15:0], 16'h2222);
        check("c_oor_rd", if_c.rdat[31:16], 16'h0);
        check("c_oor_rb", if_c.rbusy[1], 1'b0);
        check("c_oor_rsv_ok", if_c.rsv_ok, 1'b0);
        tick();
        if_c.wen = 2'b00; if_c.rsv_en = 1'b0;
        #1;
        check("c_collide_stored", if_c.rdat[15:0], 16'h2222);
        check("c_oor_cnt", if_c.busy_cnt, 5'd0);
        tick();
        for (int r = 1; r < 24; r++) begin
            if_c.rsv_en = 1'b1; if_c.rsv_sel = 5'(r);
            #1;
            check($sformatf("c_fill_ok_r%0d", r), if_c.rsv_ok, 1'b1);
            tick();
        end
        if_c.rsv_en = 1'b0;
        check("c_fill_cnt", if_c.busy_cnt, 5'd23);

        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int r = 0; r < 24; r++) begin
            m_mem[r] = '0;
            m_busy[r] = 1'b0;
        end

        for (int cyc = 0; cyc < 400; cyc++) begin
            r_wen = 2'($urandom_range(0, 3));
            r_en  = 1'($urandom_range(0, 1));
            r_rs  = $urandom_range(0, 31);
            for (int i = 0; i < 2; i++) begin
                r_ws[i] = $urandom_range(0, 31);
                r_wd[i] = 16'($urandom);
            end
            for (int k = 0; k < 3; k++) begin
                r_rd[k] = ($urandom_range(0, 3) == 0) ? r_ws[$urandom_range(0, 1)] : $urandom_range(0, 31);
            end
            if_c.wen     = r_wen;
            if_c.wsel    = {5'(r_ws[1]), 5'(r_ws[0])};
            if_c.wdat    = {r_wd[1], r_wd[0]};
            if_c.rsv_en  = r_en;
            if_c.rsv_sel = 5'(r_rs);
            if_c.rsel    = {5'(r_rd[2]), 5'(r_rd[1]), 5'(r_rd[0])};
            #1;
            for (int k = 0; k < 3; k++) begin
                if (r_rd[k] == 0 || r_rd[k] >= 24) begin
                    e_d = '0;
                    e_b = 1'b0;
                end else begin
                    e_d = m_mem[r_rd[k]];
                    e_b = m_busy[r_rd[k]];
                    for (int i = 0; i < 2; i++) begin
                        if (r_wen[i] && r_ws[i] == r_rd[k]) begin
                            e_d = r_wd[i];
                            e_b = 1'b0;
                        end
                    end
                end
                check($sformatf("c_rand%0d_rd%0d", cyc, k), if_c.rdat[k*16 +: 16], e_d);
                check($sformatf("c_rand%0d_rb%0d", cyc, k), if_c.rbusy[k], e_b);
            end
            if (!r_en || r_rs >= 24) e_ok = 1'b0;
            else if (r_rs == 0)      e_ok = 1'b1;
            else                     e_ok = !m_busy[r_rs];
            check($sformatf("c_rand%0d_ok", cyc), if_c.rsv_ok, e_ok);
            tick();
            for (int i = 0; i < 2; i++) begin
                if (r_wen[i] && r_ws[i] > 0 && r_ws[i] < 24) begin
                    m_mem[r_ws[i]]  = r_wd[i];
                    m_busy[r_ws[i]] = 1'b0;
                end
            end
            if (e_ok && r_rs > 0 && r_rs < 24) m_busy[r_rs] = 1'b1;
            e_cnt = 0;
            for (int r = 0; r < 24; r++) e_cnt += int'(m_busy[r]);
            check($sformatf("c_rand%0d_cnt", cyc), if_c.busy_cnt, 64'(e_cnt));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised successor to the single-cycle CPU register file.
- Provides configurable data width, register count, read-port count and write-port count.
- Adds optional write-to-read bypass and a per-register pending (scoreboard) bit with a reservation handshake and a live pending-count.
- Sits in the decode stage of the pipelined datapath: read ports feed operand fetch, write ports come from writeback, and the reservation port is driven by issue.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers (>=2); ADDR_W = $clog2(NUM_REGS) is a derived localparam
NUM_RD, 2, number of read ports
NUM_WR, 1, number of write ports
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never pending

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
rsel  in  NUM_RD*ADDR_W  read selects; port k occupies bits [k*ADDR_W +: ADDR_W]
rdat  out  NUM_RD*DATA_W  read data per port (combinational)
rbusy  out  NUM_RD  pending bit of the selected register per port (combinational)
wen  in  NUM_WR  write enables
wsel  in  NUM_WR*ADDR_W  write selects
wdat  in  NUM_WR*DATA_W  write data
rsv_en  in  1  reservation request: mark rsv_sel pending
rsv_sel  in  ADDR_W  register to reserve
rsv_ok  out  1  reservation accepted this cycle (combinational)
busy_cnt  out  $clog2(NUM_REGS+1)  number of registers currently pending (registered)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. RST sampled high at a rising CLK clears every register, every pending bit and busy_cnt to 0. RST overrides all same-cycle writes and reservations. Combinational outputs keep reflecting current state while RST is asserted.
- Write port i, wen[i]=1:
  - At the next edge, reg[wsel[i]] <= wdat[i] and busy[wsel[i]] <= 0.
  - Several ports writing the same address in one cycle: highest port index wins.
- ZERO_REG=1:
  - Writes and reservations to address 0 are dropped.
  - Reads of address 0 return 0 with rbusy=0.
  - rsv_ok=1 for address 0 (accepted no-op).
- Read port k, fully combinational:
  - BYPASS=0: rdat = reg[rsel[k]] and rbusy = busy[rsel[k]].
  - BYPASS=1 with any wen[i] & wsel[i]==rsel[k] (write not dropped): rdat = wdat of the highest matching i, and rbusy = 0.
  - Otherwise identical to BYPASS=0.
- Write latency: data is visible on reads at the cycle after the write. With BYPASS=1 it is also visible in the same cycle.
- Reservation handshake:
  - rsv_ok = rsv_en & ~busy[rsv_sel], independent of same-cycle writes.
  - When rsv_ok=1, busy[rsv_sel] <= 1 at the next edge.
  - When rsv_en=1 and rsv_ok=0, there is no state change; the requester must hold and retry.
  - rsv_en=0 forces rsv_ok=0.
- Same-cycle write and accepted reservation to the same register: the data is written and the pending bit ends 1 (the new producer wins).
- Write to a non-pending register: data is written and busy stays 0 (legal).
- busy_cnt:
  - Next value is the popcount of the next busy vector, so it changes in the same cycle as busy.
  - Range is 0..NUM_REGS, or NUM_REGS-1 when ZERO_REG=1.
  - It must never wrap.
- Out-of-range address (NUM_REGS not a power of two, address >= NUM_REGS):
  - Read returns 0 with rbusy=0.
  - Write is ignored.
  - rsv_ok=0.
- No X propagation: every output is defined from the first cycle after reset.

Test Plan:
- Reset/default params: RST=1 for 2 cycles, then read all 32 regs → rdat=0, rbusy=0, busy_cnt=0. Write 0xDEADBEEF to r5, then RST=1 for one cycle → r5 reads 0.
- Write/read latency, BYPASS=0: write 0x1234 to r7 at cycle n with rsel0=7 → rdat0 shows the old value at n and 0x1234 at n+1. With BYPASS=1, rdat0=0x1234 already at n.
- Zero register: write 0xFFFFFFFF to r0 and reserve r0 → rdat=0 next cycle, rbusy=0, rsv_ok=1, busy_cnt unchanged.
- Scoreboard:
  - Reserve r3 → rsv_ok=1, busy_cnt=1, rbusy(r3)=1.
  - Reserve r3 again → rsv_ok=0, busy_cnt=1.
  - Write r3=0xA5 → busy clears next cycle, busy_cnt=0. With BYPASS=1, rbusy=0 already during the write cycle.
- Simultaneous write and reserve of r9 in the same cycle → r9=written data, busy[9]=1, busy_cnt+1.
- NUM_WR=2, NUM_RD=3, DATA_W=16, NUM_REGS=24:
  - Both ports write r4 (0x1111 on port 0, 0x2222 on port 1) → r4=0x2222.
  - Read r30 → 0, rbusy=0.
  - Reserve r30 → rsv_ok=0.
  - Reserve all of r1..r23 → busy_cnt=23.
